// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming decode engine: controller
// states, correction flag codes and codeword bit-position constants.
package hamming_pkg;

    // Codeword and payload widths.
    localparam int CW_W   = 16;
    localparam int DATA_W = 11;

    // Controller states. IDLE waits for a request, the four middle states
    // move one message, FIN holds done until the next request.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        FIN   = 3'd5
    } state_t;

    // Correction flag codes written into the top two bits of the high byte.
    localparam logic [1:0] FLAG_OK  = 2'b00;  // clean codeword
    localparam logic [1:0] FLAG_FIX = 2'b01;  // single error corrected
    localparam logic [1:0] FLAG_DBL = 2'b10;  // double error, not corrected

    // Overall-parity bit position. A single error that leaves the syndrome
    // at zero must have hit this bit.
    localparam int POS_P0 = 0;

    // Codeword positions of data bits d1..d11 (index 0 holds d1). Every
    // position that is not a power of two, and not zero, carries data.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    // Gather the eleven data bits from a codeword, d1 in bit 0.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder for one 16-bit extended Hamming codeword.
// Computes the syndrome and overall parity, repairs a single-bit error
// and reports what it found through a two-bit flag.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   codeword_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        flag_o
);

    logic [3:0]      syndrome;
    logic            parity;
    logic [3:0]      err_pos;
    logic [CW_W-1:0] fixed_cw;

    // Syndrome, overall parity, correction and flag classification.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        syndrome = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (codeword_i[k]) begin
                syndrome = syndrome ^ k[3:0];
            end
        end

        parity = ^codeword_i;

        // With odd parity the syndrome points at the flipped bit; a zero
        // syndrome means the overall parity bit itself flipped.
        err_pos  = (syndrome == 4'd0) ? 4'(POS_P0) : syndrome;
        fixed_cw = codeword_i;
        if (parity) begin
            fixed_cw[err_pos] = ~codeword_i[err_pos];
        end

        // Even parity with a non-zero syndrome is a double error; the data is
        // left exactly as received in that case.
        if (parity) begin
            flag_o = FLAG_FIX;
        end else if (syndrome != 4'd0) begin
            flag_o = FLAG_DBL;
        end else begin
            flag_o = FLAG_OK;
        end

        data_o = extract_data(fixed_cw);
    end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-to-memory SECDED decode engine. On a request it walks NUM_MSG
// codewords stored little-endian at SRC_BASE, decodes each and writes the
// 11-bit payload plus a 2-bit flag, little-endian, at DST_BASE. Every
// message takes exactly four cycles: read low, read high, write low,
// write high.
module hamming_dec_engine
    import hamming_pkg::*;
#(
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int NUM_MSG  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    // Address bases and last index, in the 8-bit domain of the memory bus.
    localparam logic [7:0] SRC_B    = SRC_BASE[7:0];
    localparam logic [7:0] DST_B    = DST_BASE[7:0];
    localparam logic [7:0] LAST_IDX = 8'(NUM_MSG - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] lo_q,    lo_d;
    logic [7:0] hi_q,    hi_d;

    logic [DATA_W-1:0] dec_data;
    logic [1:0]        dec_flag;
    logic [7:0]        offs;

    // Decode the codeword held in the byte latches.
    hamming_secded_dec u_dec (
        .codeword_i ({hi_q, lo_q}),
        .data_o     (dec_data),
        .flag_o     (dec_flag)
    );

    // Byte offset of the current message inside either buffer.
    assign offs = idx_q << 1;

    // Next-state logic: sequencing, message index and byte latching.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        unique case (state_q)
            IDLE, FIN: begin
                // A request starts a fresh run from message 0.
                if (req) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                end
            end
            RD_LO: begin
                lo_d    = mem_rd_data;
                state_d = RD_HI;
            end
            RD_HI: begin
                hi_d    = mem_rd_data;
                state_d = WR_LO;
            end
            WR_LO: begin
                state_d = WR_HI;
            end
            WR_HI: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory bus and done are decoded from the current state only, so they
    // follow an asynchronous reset without waiting for a clock edge.
    always_comb begin
        done        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        unique case (state_q)
            RD_LO: begin
                mem_addr = SRC_B + offs;
            end
            RD_HI: begin
                mem_addr = SRC_B + offs + 8'd1;
            end
            WR_LO: begin
                mem_addr    = DST_B + offs;
                mem_wr_en   = 1'b1;
                mem_wr_data = dec_data[7:0];
            end
            WR_HI: begin
                mem_addr    = DST_B + offs + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = {dec_flag, 3'b000, dec_data[10:8]};
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // State, index and byte-latch registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the byte latches are cleared along with the control state
            // so a run aborted by reset leaves no stale codeword behind.
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the same pre-edge values, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Directed bench for hamming_dec_engine: hand-computed vectors, random
// valid codewords with 0/1/2 flipped bits, latency, mid-run req pulses
// and reset abort.
module tb_hamming_dec_engine;

    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int N   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [256];
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    int         wr_count = 0;

    int tests = 0;
    int fails = 0;

    logic [15:0] src_word [N];
    logic [15:0] exp_word [N];

    hamming_dec_engine #(
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .NUM_MSG  (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge. The bench
    // loads it through a side port while the engine is not writing.
    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load_src();
        for (int m = 0; m < N; m++) begin
            poke(8'(SRC + 2 * m),     src_word[m][7:0]);
            poke(8'(SRC + 2 * m + 1), src_word[m][15:8]);
        end
    endtask

    task automatic fill_dst();
        for (int i = 0; i < 2 * N; i++) begin
            poke(8'(DST + i), 8'hAA);
        end
    endtask

    task automatic check_dst();
        for (int m = 0; m < N; m++) begin
            check($sformatf("dst_lo[%0d]", m), mem[DST + 2 * m],     exp_word[m][7:0]);
            check($sformatf("dst_hi[%0d]", m), mem[DST + 2 * m + 1], exp_word[m][15:8]);
        end
    endtask

    // Issue a one-cycle req and count edges until done; optionally pulse
    // req while the run is active. Called and returns on a falling edge.
    task automatic run_timed(input bit pulses);
        int cycles;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("done_drop", done, 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            req = pulses && (cycles == 10 || cycles == 33 || cycles == 58);
        end
        req = 1'b0;
        check("done_latency", cycles, 60);
    endtask

    // Valid extended Hamming codeword for 11 data bits.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        c        = '0;
        c[3]     = d[0];
        c[7:5]   = d[3:1];
        c[15:9]  = d[10:4];
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int k = 1; k < 16; k++) begin
                if ((k & (1 << b)) != 0) p = p ^ c[k];
            end
            c[1 << b] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Expected {hi, lo} output for one received codeword.
    function automatic logic [15:0] model_decode(input logic [15:0] c);
        logic [3:0]  s;
        logic        p;
        logic [15:0] cc;
        logic [10:0] d;
        logic [1:0]  f;
        s[0] = c[1] ^ c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
        s[1] = c[2] ^ c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        s[2] = c[4] ^ c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        s[3] = ^c[15:8];
        p    = ^c;
        cc   = c;
        if (p) begin
            f = 2'b01;
            if (s != 4'd0) cc[s] = ~cc[s];
        end else if (s != 4'd0) begin
            f = 2'b10;
        end else begin
            f = 2'b00;
        end
        d = {cc[15:9], cc[7:5], cc[3]};
        return {f, 3'b000, d[10:8], d[7:0]};
    endfunction

    // Random valid codewords with m%3 distinct flipped bits.
    task automatic make_random();
        int          p1, p2;
        logic [15:0] c;
        for (int m = 0; m < N; m++) begin
            c  = encode(11'($urandom_range(0, 2047)));
            p1 = $urandom_range(0, 15);
            p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
            if (m % 3 >= 1) c[p1] = ~c[p1];
            if (m % 3 == 2) c[p2] = ~c[p2];
            src_word[m] = c;
            exp_word[m] = model_decode(c);
        end
    endtask

    initial begin
        int base;
        reset = 1'b1;
        req   = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (3) @(negedge clk);

        check("rst_done",    done,        0);
        check("rst_addr",    mem_addr,    0);
        check("rst_wr_en",   mem_wr_en,   0);
        check("rst_wr_data", mem_wr_data, 0);

        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_done",   done,     0);
        check("idle_addr",   mem_addr, 0);
        check("idle_writes", wr_count, 0);

        // Directed vectors in messages 0..3, zero codewords elsewhere.
        for (int m = 0; m < N; m++) begin
            src_word[m] = 16'h0000;
            exp_word[m] = 16'h0000;
        end
        src_word[0] = 16'hFFFF; exp_word[0] = 16'h07FF;  // clean, all ones
        src_word[1] = 16'h0020; exp_word[1] = 16'h4000;  // c5 flipped
        src_word[2] = 16'h0001; exp_word[2] = 16'h4000;  // p0 flipped
        src_word[3] = 16'h0030; exp_word[3] = 16'h8002;  // c5 and c4 flipped
        load_src();
        fill_dst();
        base = wr_count;
        run_timed(1'b0);
        check("run1_writes", wr_count - base, 30);
        check_dst();

        repeat (5) @(negedge clk);
        check("fin_done_hold", done,        1);
        check("fin_addr",      mem_addr,    0);
        check("fin_wr_en",     mem_wr_en,   0);
        check("fin_wr_data",   mem_wr_data, 0);

        // Random codewords, restarted from FIN, with req pulses mid-run.
        make_random();
        load_src();
        fill_dst();
        base = wr_count;
        run_timed(1'b1);
        check("run2_writes", wr_count - base, 30);
        check_dst();

        // Reset 20 cycles into a run: messages 0..4 written, nothing after.
        make_random();
        load_src();
        fill_dst();
        base = wr_count;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_writes_before", wr_count - base, 10);
        check("abort_addr_before",   mem_addr, 8'(SRC + 10));
        reset = 1'b1;
        #1;
        check("abort_done",    done,        0);
        check("abort_addr",    mem_addr,    0);
        check("abort_wr_en",   mem_wr_en,   0);
        check("abort_wr_data", mem_wr_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        check("abort_writes_after", wr_count - base, 10);
        check("abort_done_after",   done, 0);

        // Full run after the abort.
        make_random();
        load_src();
        fill_dst();
        base = wr_count;
        run_timed(1'b1);
        check("run4_writes", wr_count - base, 30);
        check_dst();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hamming_dec_engine.md
HAMMING_DEC_ENGINE -- requirements
Module: hamming_dec_engine

Interface
REQ-001 SHALL have parameter SRC_BASE, default 30, byte address of first encoded word (low byte; high byte at +1).
REQ-002 SHALL have parameter DST_BASE, default 0, byte address of first decoded word (low byte; high byte at +1).
REQ-003 SHALL have parameter NUM_MSG, default 15, number of 16-bit codewords processed per request.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  start request, sampled on rising clk.
REQ-007 done  output  1  high when the run has finished.
REQ-008 mem_addr  output  8  data-memory byte address.
REQ-009 mem_rd_data  input  8  data-memory read data, combinational from mem_addr within the same cycle.
REQ-010 mem_wr_en  output  1  write strobe; memory writes mem_wr_data to mem_addr on the rising edge.
REQ-011 mem_wr_data  output  8  write data.

Function
REQ-012 SHALL implement FSM states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN.
REQ-013 IDLE: req=1 -> RD_LO with message index i=0; otherwise stay in IDLE.
REQ-014 RD_LO: mem_addr=SRC_BASE+2i; low byte latched; -> RD_HI.
REQ-015 RD_HI: mem_addr=SRC_BASE+2i+1; high byte latched; -> WR_LO.
REQ-016 WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, mem_wr_data=d[8:1]; -> WR_HI.
REQ-017 WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, mem_wr_data={F[1:0],3'b000,d[11:9]}; i==NUM_MSG-1 -> FIN, else i+1 and -> RD_LO.
REQ-018 Each message SHALL take exactly 4 cycles; done SHALL rise NUM_MSG*4 cycles after the req-sampling edge (60 at defaults).
REQ-019 FIN: done=1, held until the next req; req=1 in FIN restarts at RD_LO with i=0, and done SHALL drop that edge.
REQ-020 req SHALL be ignored in RD_LO, RD_HI, WR_LO and WR_HI.
REQ-021 Codeword c[15:0]={hi,lo}={d11..d5,p8,d4,d3,d2,p4,d1,p2,p1,p0}; data bits SHALL be taken from c[15:9], c[7:5] and c[3].
REQ-022 Syndrome s[3:0] SHALL be the XOR of all indices k in 1..15 with c[k]=1; overall parity P SHALL be ^c[15:0].
REQ-023 s=0, P=0: F=00, data passed through.
REQ-024 P=1: F=01; if s!=0, c[s] SHALL be inverted before data extraction; if s=0 (p0 error), data passed through.
REQ-025 s!=0, P=0: F=10; data extracted uncorrected.
REQ-026 mem_wr_en SHALL be 0 in every state except WR_LO and WR_HI; mem_addr and mem_wr_data SHALL be 0 in IDLE and FIN.
REQ-027 Index arithmetic SHALL be 8-bit, with no wrap handling required for legal parameters (SRC_BASE+2*NUM_MSG <= 256).

Reset
REQ-028 reset asserted SHALL immediately force IDLE, i=0, latches=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, regardless of clk.
REQ-029 Reset mid-run SHALL abort without any further write; a following req SHALL perform a complete run from i=0.

Structure
REQ-030 Shared package hamming_pkg SHALL hold the state enum, the F codes (FLAG_OK=00, FLAG_FIX=01, FLAG_DBL=10) and codeword bit-position constants.
REQ-031 A combinational sub-module hamming_secded_dec (in 16-bit codeword; out 11-bit data, 2-bit flag) SHALL hold the syndrome, parity and correction logic.

Verification
REQ-032 Codeword hi=0xFF, lo=0xFF at SRC_BASE -> DST_BASE hi=0x07, lo=0xFF (F=00).
REQ-033 hi=0x00, lo=0x20 (single error at c5) -> hi=0x40, lo=0x00 (corrected, F=01).
REQ-034 hi=0x00, lo=0x01 (p0 error only) -> hi=0x40, lo=0x00.
REQ-035 hi=0x00, lo=0x30 (double error at c5 and c4) -> hi=0x80, lo=0x02 (uncorrected, F=10).
REQ-036 15 random valid codewords with random 0/1/2-bit flips, matched against a bench-model decode: all 30 destination bytes match and done rises exactly 60 cycles after req; req pulses mid-run leave the timing unchanged.
REQ-037 reset asserted at cycle 20 of a run -> done=0 and no writes until the next req, whose run completes correctly.
